// File: rtl/usr_multimode_if.sv
// ---------------------------------------------------------------------------
// usr_multimode_if
//   Command / data bundle for the multimode universal shift register.
//   The master side issues commands and supplies the parallel and serial
//   inputs. The slave side is the register itself, which returns its
//   contents, the serial taps and the busy/done handshake.
//
//   start      command request (sampled by the register only in IDLE)
//   mode       operation code
//   amount     shift count
//   par_in     parallel load data
//   ser_in_l   serial fill entering at the MSB (SHR)
//   ser_in_r   serial fill entering at the LSB (SHL)
//   q          register contents
//   ser_out_l  q[WIDTH-1]
//   ser_out_r  q[0]
//   busy       high while a multi-step shift is running
//   done       one-cycle completion pulse
// ---------------------------------------------------------------------------
interface usr_multimode_if #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 3
);
    logic                start;
    logic [2:0]          mode;
    logic [SHAMT_W-1:0]  amount;
    logic [WIDTH-1:0]    par_in;
    logic                ser_in_l;
    logic                ser_in_r;
    logic [WIDTH-1:0]    q;
    logic                ser_out_l;
    logic                ser_out_r;
    logic                busy;
    logic                done;

    modport master (
        output start, mode, amount, par_in, ser_in_l, ser_in_r,
        input  q, ser_out_l, ser_out_r, busy, done
    );

    modport slave (
        input  start, mode, amount, par_in, ser_in_l, ser_in_r,
        output q, ser_out_l, ser_out_r, busy, done
    );
endinterface

// File: rtl/usr_multimode.sv
// ---------------------------------------------------------------------------
// usr_multimode
//   Parametrised universal shift register with HOLD, SHL, SHR, ROL, ROR,
//   ASR, LOAD and CLEAR modes. A shift command moves the register by one
//   position per enabled clock, for 'amount' clocks, under a
//   start/busy/done handshake. Single-cycle commands (HOLD, LOAD, CLEAR,
//   and shifts by zero) complete on the start edge.
//
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   ena    design enable; low freezes all state, including done
//   bus    usr_multimode_if slave side (command fields, serial fills,
//          q, serial taps, busy, done)
// ---------------------------------------------------------------------------
module usr_multimode #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    usr_multimode_if.slave   bus
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_SHL   = 3'b001;
    localparam logic [2:0] MODE_SHR   = 3'b010;
    localparam logic [2:0] MODE_ROL   = 3'b011;
    localparam logic [2:0] MODE_ROR   = 3'b100;
    localparam logic [2:0] MODE_ASR   = 3'b101;
    localparam logic [2:0] MODE_LOAD  = 3'b110;
    localparam logic [2:0] MODE_CLEAR = 3'b111;

    localparam logic [SHAMT_W-1:0] CNT_ZERO = SHAMT_W'(1'b0);
    localparam logic [SHAMT_W-1:0] CNT_ONE  = SHAMT_W'(1'b1);

    logic [1:0]          state_r;
    logic [2:0]          mode_r;
    logic [SHAMT_W-1:0]  cnt_r;
    logic [WIDTH-1:0]    q_r;
    logic                busy_r;
    logic                done_r;
    logic [WIDTH-1:0]    step_s;

    // True for the modes that move bits one position per step.
    function automatic logic is_shift(input logic [2:0] op);
        logic res;
        case (op)
            MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_ASR: res = 1'b1;
            default:                                          res = 1'b0;
        endcase
        return res;
    endfunction

    // One-position step of a shift mode; non-shift codes leave the value alone.
    function automatic logic [WIDTH-1:0] shift_step(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] val,
        input logic             fill_l,
        input logic             fill_r
    );
        logic [WIDTH-1:0] res;
        case (op)
            MODE_SHL: res = {val[WIDTH-2:0], fill_r};
            MODE_SHR: res = {fill_l, val[WIDTH-1:1]};
            MODE_ROL: res = {val[WIDTH-2:0], val[WIDTH-1]};
            MODE_ROR: res = {val[0], val[WIDTH-1:1]};
            MODE_ASR: res = {val[WIDTH-1], val[WIDTH-1:1]};
            default:  res = val;
        endcase
        return res;
    endfunction

    // Next value for a RUN step, using the mode latched at the start edge
    // and the serial fills live on this edge.
    always_comb begin
        step_s = shift_step(mode_r, q_r, bus.ser_in_l, bus.ser_in_r);
    end

    // Command FSM, step counter and register contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            mode_r  <= MODE_HOLD;
            cnt_r   <= CNT_ZERO;
            q_r     <= {WIDTH{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else if (ena) begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        mode_r <= bus.mode;
                        case (bus.mode)
                            MODE_LOAD:  q_r <= bus.par_in;
                            MODE_CLEAR: q_r <= {WIDTH{1'b0}};
                            default:    q_r <= q_r;
                        endcase
                        // A shift by zero collapses into a single-cycle command.
                        if (is_shift(bus.mode) && (bus.amount != CNT_ZERO)) begin
                            cnt_r   <= bus.amount;
                            busy_r  <= 1'b1;
                            state_r <= ST_RUN;
                        end else begin
                            done_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end
                    end
                end
                ST_RUN: begin
                    q_r   <= step_s;
                    cnt_r <= cnt_r - CNT_ONE;
                    // The last step leaves RUN on the same edge it is applied.
                    if (cnt_r == CNT_ONE) begin
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    cnt_r   <= CNT_ZERO;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.q         = q_r;
    assign bus.ser_out_l = q_r[WIDTH-1];
    assign bus.ser_out_r = q_r[0];
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;

endmodule

// File: tb/tb_usr_multimode.sv
// ---------------------------------------------------------------------------
// tb_usr_multimode
//   Self-checking bench for usr_multimode (WIDTH=8, SHAMT_W=3). Expected
//   register values come from an arithmetic reference model (multiply,
//   divide, modulo on integers) applied once per enabled shift edge.
//   Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_usr_multimode;

    logic clk;
    logic rst_n;
    logic ena;
    int   n_tests;
    int   n_fail;
    logic [7:0] m_q;

    usr_multimode_if #(.WIDTH(8), .SHAMT_W(3)) bus ();

    usr_multimode #(.WIDTH(8), .SHAMT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time limit in case the design wedges the bench.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // One shift step computed with integer arithmetic.
    function automatic logic [7:0] ref_step(input logic [2:0] md, input logic [7:0] v,
                                            input logic sl, input logic sr);
        int x;
        int r;
        x = int'(v);
        case (md)
            3'd1:    r = (x * 2 + int'(sr)) % 256;
            3'd2:    r = x / 2 + int'(sl) * 128;
            3'd3:    r = (x * 2) % 256 + x / 128;
            3'd4:    r = x / 2 + (x % 2) * 128;
            3'd5:    r = x / 2 + (x / 128) * 128;
            default: r = x;
        endcase
        return 8'(r);
    endfunction

    // Issue one command from IDLE and observe it through to completion.
    // Returns observations only; callers compare them with expectations.
    task automatic run_cmd(input logic [2:0] md, input logic [2:0] amt, input logic [7:0] par,
                           input int pat, input int gap_at,
                           output int busy_cnt, output int lat, output logic [7:0] q_done,
                           output logic done_after, output int aux_bad);
        int steps_left;
        int edges;
        logic [7:0] frozen;
        logic sl;
        logic sr;
        steps_left = (md >= 3'd1 && md <= 3'd5) ? int'(amt) : 0;
        if (md == 3'd6) m_q = par;
        else if (md == 3'd7) m_q = 8'h00;
        bus.start    = 1'b1;
        bus.mode     = md;
        bus.amount   = amt;
        bus.par_in   = par;
        bus.ser_in_l = 1'($urandom);
        bus.ser_in_r = 1'($urandom);
        busy_cnt = 0;
        lat      = -1;
        q_done   = 8'hxx;
        aux_bad  = 0;
        @(negedge clk);
        edges = 1;
        while (edges < 40 && lat < 0) begin
            if (bus.done === 1'b1) begin
                lat    = edges;
                q_done = bus.q;
            end else begin
                if (bus.busy === 1'b1) busy_cnt++;
                if (bus.ser_out_r !== bus.q[0] || bus.ser_out_l !== bus.q[7]) aux_bad++;
                // Fresh start requests and field changes must not disturb a running command.
                bus.start  = 1'b1;
                bus.mode   = 3'($urandom);
                bus.amount = 3'($urandom);
                bus.par_in = 8'($urandom);
                if (edges == gap_at) begin
                    frozen = bus.q;
                    ena = 1'b0;
                    repeat (2) begin
                        @(negedge clk);
                        if (bus.q !== frozen || bus.busy !== 1'b1 || bus.done !== 1'b0) aux_bad++;
                    end
                    ena = 1'b1;
                end
                if (pat == 1) begin
                    sl = 1'b0;
                    sr = ((int'(amt) - steps_left) % 2 == 0);
                end else begin
                    sl = 1'($urandom);
                    sr = 1'($urandom);
                end
                bus.ser_in_l = sl;
                bus.ser_in_r = sr;
                if (steps_left > 0) begin
                    m_q = ref_step(md, m_q, sl, sr);
                    steps_left--;
                end
                @(negedge clk);
                edges++;
            end
        end
        // start stays high across the DONE edge, where it must be ignored.
        @(negedge clk);
        done_after = bus.done;
        if (bus.busy !== 1'b0) aux_bad++;
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        int bad;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (bus.q !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_initial: q=%h busy=%b done=%b, need q=00 busy=0 done=0", bus.q, bus.busy, bus.done);
        end
        rst_n = 1'b1;
        @(negedge clk);
        bus.start = 1'b1; bus.mode = 3'd6; bus.par_in = 8'h3C; bus.amount = 3'd0;
        @(negedge clk);
        bus.start = 1'b1; bus.mode = 3'd1; bus.amount = 3'd5; bus.ser_in_r = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_setup_busy: busy=%b, need 1", bus.busy);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.q !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_midrun: q=%h busy=%b done=%b, need q=00 busy=0 done=0", bus.q, bus.busy, bus.done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_q = 8'h00;
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.q !== 8'h00) bad++;
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL reset_aborted: %0d cycles with activity after release, need 0", bad);
        end
    endtask

    task automatic test_idle_after_reset();
        int bc, lat, bad; logic [7:0] qd; logic da;
        run_cmd(3'd6, 3'd0, 8'h5A, 0, -1, bc, lat, qd, da, bad);
        n_tests++;
        if (lat !== 1 || qd !== 8'h5A) begin
            n_fail++;
            $display("FAIL idle_after_reset: latency=%0d q=%h, need latency=1 q=5a", lat, qd);
        end
    endtask

    task automatic test_rol();
        int bc, lat, bad; logic [7:0] qd; logic da;
        run_cmd(3'd6, 3'd0, 8'hA5, 0, -1, bc, lat, qd, da, bad);
        run_cmd(3'd3, 3'd3, 8'h00, 0, -1, bc, lat, qd, da, bad);
        n_tests++;
        if (qd !== 8'h2D) begin n_fail++; $display("FAIL rol3_q: got %h need 2d", qd); end
        n_tests++;
        if (bc !== 3) begin n_fail++; $display("FAIL rol3_busy_cycles: got %0d need 3", bc); end
        n_tests++;
        if (lat !== 4) begin n_fail++; $display("FAIL rol3_latency: got %0d need 4", lat); end
        n_tests++;
        if (da !== 1'b0 || bad !== 0) begin
            n_fail++;
            $display("FAIL rol3_done_pulse: done_after=%b aux=%0d, need 0 and 0", da, bad);
        end
    endtask

    task automatic test_asr_shr();
        int bc, lat, bad; logic [7:0] qd; logic da;
        run_cmd(3'd6, 3'd0, 8'h81, 0, -1, bc, lat, qd, da, bad);
        run_cmd(3'd5, 3'd2, 8'h00, 0, -1, bc, lat, qd, da, bad);
        n_tests++;
        if (qd !== 8'hE0 || lat !== 3) begin
            n_fail++;
            $display("FAIL asr2: q=%h latency=%0d, need q=e0 latency=3", qd, lat);
        end
        run_cmd(3'd2, 3'd1, 8'h00, 1, -1, bc, lat, qd, da, bad);
        n_tests++;
        if (qd !== 8'h70 || lat !== 2) begin
            n_fail++;
            $display("FAIL shr1: q=%h latency=%0d, need q=70 latency=2", qd, lat);
        end
    endtask

    task automatic test_shl_serial();
        int bc, lat, bad; logic [7:0] qd; logic da;
        run_cmd(3'd6, 3'd0, 8'h00, 0, -1, bc, lat, qd, da, bad);
        run_cmd(3'd1, 3'd7, 8'h00, 1, -1, bc, lat, qd, da, bad);
        n_tests++;
        if (qd !== 8'h55 || lat !== 8) begin
            n_fail++;
            $display("FAIL shl7_serial: q=%h latency=%0d, need q=55 latency=8", qd, lat);
        end
        n_tests++;
        if (bad !== 0 || bus.ser_out_r !== bus.q[0] || bus.ser_out_l !== bus.q[7]) begin
            n_fail++;
            $display("FAIL ser_out_tracking: %0d bad samples, need 0", bad);
        end
    endtask

    task automatic test_ror_gap();
        int bc, lat, bad; logic [7:0] qd; logic da; logic [7:0] v; int exp_i;
        v = 8'($urandom);
        exp_i = int'(v) / 16 + (int'(v) % 16) * 16;
        run_cmd(3'd6, 3'd0, v, 0, -1, bc, lat, qd, da, bad);
        run_cmd(3'd4, 3'd4, 8'h00, 0, 2, bc, lat, qd, da, bad);
        n_tests++;
        if (qd !== 8'(exp_i)) begin n_fail++; $display("FAIL ror4_gap_q: got %h need %h", qd, 8'(exp_i)); end
        n_tests++;
        if (lat !== 5 || bc !== 4) begin
            n_fail++;
            $display("FAIL ror4_gap_timing: latency=%0d busy=%0d, need 5 and 4", lat, bc);
        end
        n_tests++;
        if (bad !== 0) begin n_fail++; $display("FAIL ror4_gap_freeze: %0d bad samples, need 0", bad); end
    endtask

    task automatic test_zero_and_clear();
        int bc, lat, bad; logic [7:0] qd; logic da; logic [7:0] v; int held;
        v = 8'($urandom_range(1, 255));
        run_cmd(3'd6, 3'd0, v, 0, -1, bc, lat, qd, da, bad);
        run_cmd(3'd1, 3'd0, 8'h00, 0, -1, bc, lat, qd, da, bad);
        n_tests++;
        if (qd !== v || lat !== 1 || bc !== 0 || da !== 1'b0) begin
            n_fail++;
            $display("FAIL shl_amount0: q=%h latency=%0d busy=%0d, need q=%h latency=1 busy=0", qd, lat, bc, v);
        end
        bus.start = 1'b1; bus.mode = 3'd7;
        @(negedge clk);
        bus.start = 1'b0;
        m_q = 8'h00;
        n_tests++;
        if (bus.done !== 1'b1 || bus.q !== 8'h00) begin
            n_fail++;
            $display("FAIL clear: done=%b q=%h, need done=1 q=00", bus.done, bus.q);
        end
        ena = 1'b0;
        held = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus.done === 1'b1) held++;
        end
        ena = 1'b1;
        @(negedge clk);
        n_tests++;
        if (held !== 2 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_hold_ena_low: held=%0d done_now=%b, need 2 and 0", held, bus.done);
        end
    endtask

    task automatic test_back_to_back();
        int bc, lat, bad; logic [7:0] qd; logic da;
        logic [2:0] md; logic [2:0] amt; int exp_lat; int gap;
        for (int i = 0; i < 30; i++) begin
            md  = 3'($urandom);
            amt = 3'($urandom);
            gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : -1;
            exp_lat = (md >= 3'd1 && md <= 3'd5 && amt != 3'd0) ? int'(amt) + 1 : 1;
            run_cmd(md, amt, 8'($urandom), 0, gap, bc, lat, qd, da, bad);
            n_tests++;
            if (qd !== m_q || lat !== exp_lat || bc !== exp_lat - 1 || da !== 1'b0 || bad !== 0) begin
                n_fail++;
                $display("FAIL random_cmd%0d: mode=%0d n=%0d q=%h lat=%0d busy=%0d done_after=%b aux=%0d, need q=%h lat=%0d busy=%0d done_after=0 aux=0",
                         i, md, amt, qd, lat, bc, da, bad, m_q, exp_lat, exp_lat - 1);
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_q     = 8'h00;
        rst_n   = 1'b0;
        ena     = 1'b1;
        bus.start    = 1'b0;
        bus.mode     = 3'd0;
        bus.amount   = 3'd0;
        bus.par_in   = 8'h00;
        bus.ser_in_l = 1'b0;
        bus.ser_in_r = 1'b0;
        @(negedge clk);
        test_reset();
        test_idle_after_reset();
        test_rol();
        test_asr_shr();
        test_shl_serial();
        test_ror_gap();
        test_zero_and_clear();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
